// File: rtl/mips_pkg.sv
// Shared MIPS encodings: main-opcode constants also used by the control unit,
// bundle-kind codes accepted by the encoder, and the loader state encoding.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned KIND_W   = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;

    localparam logic [KIND_W-1:0] KIND_R   = 2'b00;
    localparam logic [KIND_W-1:0] KIND_LW  = 2'b01;
    localparam logic [KIND_W-1:0] KIND_SW  = 2'b10;
    localparam logic [KIND_W-1:0] KIND_BEQ = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction kind plus fields -> 32-bit MIPS word.
module instr_pack
    import mips_pkg::*;
(
    input  logic [KIND_W-1:0]   i_kind,
    input  logic [REG_W-1:0]    i_rs,
    input  logic [REG_W-1:0]    i_rt,
    input  logic [REG_W-1:0]    i_rd,
    input  logic [REG_W-1:0]    i_shamt,
    input  logic [FUNCT_W-1:0]  i_funct,
    input  logic [IMM_W-1:0]    i_imm,
    output logic [INSTR_W-1:0]  o_word
);

    // I-types ignore rd/shamt/funct; R-type ignores imm.
    always_comb begin
        o_word = '0;
        case (i_kind)
            KIND_R:   o_word = {OP_RTYPE, i_rs, i_rt, i_rd, i_shamt, i_funct};
            KIND_LW:  o_word = {OP_LW,  i_rs, i_rt, i_imm};
            KIND_SW:  o_word = {OP_SW,  i_rs, i_rt, i_imm};
            KIND_BEQ: o_word = {OP_BEQ, i_rs, i_rt, i_imm};
            default:  o_word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder / instruction-memory loader: packs accepted
// field bundles and writes them to consecutive words starting at address 0.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 finish,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_kind,
    input  logic [4:0]           in_rs,
    input  logic [4:0]           in_rt,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_shamt,
    input  logic [5:0]           in_funct,
    input  logic [15:0]          in_imm,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_W;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_clear;
    logic [INSTR_W-1:0]   w_word;
    logic [CNT_W-1:0]     r_count;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [INSTR_W-1:0]   r_wdata;

    instr_pack u_pack (
        .i_kind  (in_kind),
        .i_rs    (in_rs),
        .i_rt    (in_rt),
        .i_rd    (in_rd),
        .i_shamt (in_shamt),
        .i_funct (in_funct),
        .i_imm   (in_imm),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the handshake/session-control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_clear     = 1'b1;
                end
            end
            ST_LOAD: begin
                in_ready = (r_count != CAPACITY);
                if (finish) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = in_valid && in_ready;

    // Counter and write-port registers; addr/data hold between accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_accept;
            if (w_clear) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_accept) begin
                r_addr  <= r_count[ADDR_W-1:0];
                r_wdata <= w_word;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = (r_count == CAPACITY);
    assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: session-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_encoder;

    localparam int unsigned AW  = 3;
    localparam int          CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]    in_funct = '0;
    logic [15:0]   in_imm = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
        .full(full), .done(done)
    );

    always #5 clk = ~clk;

    // Reference encoding straight from the MIPS field layout.
    function automatic logic [31:0] encode(input int kind, input int rs, input int rt,
                                           input int rd, input int sh, input int fn,
                                           input int imm);
        int op;
        op = (kind == 0) ? 0 : (kind == 1) ? 35 : (kind == 2) ? 43 : 4;
        if (kind == 0)
            return 32'((rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn);
        return 32'((op << 26) | (rs << 21) | (rt << 16) | (imm & 16'hFFFF));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Session-level model: loading/done flags, word count, last write.
    bit          m_loading = 0;
    bit          m_done    = 0;
    int          m_cnt     = 0;
    bit          m_we      = 0;
    int          m_addr    = 0;
    logic [31:0] m_wdata   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading = 0; m_done = 0; m_cnt = 0;
            m_we = 0; m_addr = 0; m_wdata = '0;
        end else begin
            bit was_loading;
            bit acc;
            was_loading = m_loading;
            acc = in_valid && was_loading && (m_cnt < CAP);
            m_we = acc;
            if (acc) begin
                m_addr  = m_cnt;
                m_wdata = encode(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                                 int'(in_shamt), int'(in_funct), int'(in_imm));
                m_cnt++;
            end
            if (was_loading && finish) begin
                m_loading = 0; m_done = 1;
            end else if (!was_loading && start) begin
                m_loading = 1; m_done = 0; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(m_loading && (m_cnt < CAP)));
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", mem_wdata,      m_wdata);
        chk("count",     32'(count),     32'(m_cnt));
        chk("full",      32'(full),      32'(m_cnt == CAP));
        chk("done",      32'(done),      32'(m_done));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input int kind, input int rs, input int rt, input int rd,
                              input int sh, input int fn, input int imm);
        in_kind = 2'(kind); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; step(); finish = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        chk("enc_r_add", encode(0, 1, 2, 3, 0, 32'h20, 0), 32'h00221820);
        chk("enc_lw",    encode(1, 1, 2, 0, 0, 0, 4),      32'h8C220004);
        chk("enc_beq",   encode(3, 1, 2, 0, 0, 0, 16'hFFFF), 32'h1022FFFF);
        repeat (3) step();
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_count", 32'(count),  32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // in_valid while IDLE never writes
        set_bundle(0, 7, 7, 7, 0, 32'h20, 0);
        in_valid = 1'b1; repeat (3) step(); in_valid = 1'b0;
        chk("idle_count", 32'(count), 32'd0);

        // R add
        pulse_start();
        set_bundle(0, 1, 2, 3, 0, 32'h20, 0);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("radd_we",    32'(mem_we), 32'd1);
        chk("radd_addr",  32'(mem_addr), 32'd0);
        chk("radd_wdata", mem_wdata, 32'h00221820);
        chk("radd_count", 32'(count), 32'd1);
        step();
        chk("radd_we_drop", 32'(mem_we), 32'd0);
        pulse_finish();
        chk("fin_done", 32'(done), 32'd1);

        // Back-to-back LW/SW/BEQ in a new session
        pulse_start();
        chk("restart_count", 32'(count), 32'd0);
        in_valid = 1'b1;
        set_bundle(1, 1, 2, 31, 31, 63, 4);   step();
        chk("lw_wdata", mem_wdata, 32'h8C220004);
        chk("lw_addr",  32'(mem_addr), 32'd0);
        set_bundle(2, 1, 2, 0, 0, 0, 8);      step();
        chk("sw_wdata", mem_wdata, 32'hAC220008);
        chk("sw_addr",  32'(mem_addr), 32'd1);
        set_bundle(3, 1, 2, 0, 0, 0, 16'hFFFF); step();
        chk("beq_wdata", mem_wdata, 32'h1022FFFF);
        chk("beq_addr",  32'(mem_addr), 32'd2);
        chk("beq_we",    32'(mem_we), 32'd1);

        // Keep offering past capacity: stalls, no wrap
        repeat (CAP + 2) begin
            set_bundle(int'($urandom_range(0, 3)), 4, 5, 6, 1, 2, 3);
            step();
        end
        chk("full_flag",  32'(full), 32'd1);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'(CAP));
        chk("full_we",    32'(mem_we), 32'd0);
        pulse_finish();
        in_valid = 1'b0;
        chk("full_done", 32'(done), 32'd1);

        // finish coinciding with an accept
        pulse_start();
        set_bundle(2, 9, 10, 0, 0, 0, 16'h1234);
        in_valid = 1'b1; finish = 1'b1; step(); in_valid = 1'b0; finish = 1'b0;
        chk("finacc_we",    32'(mem_we), 32'd1);
        chk("finacc_wdata", mem_wdata, 32'hAD2A1234);
        chk("finacc_done",  32'(done), 32'd1);
        chk("finacc_ready", 32'(in_ready), 32'd0);
        pulse_start();
        set_bundle(0, 1, 1, 1, 1, 1, 0);
        in_valid = 1'b1; step(); in_valid = 1'b0;
        chk("restart_addr", 32'(mem_addr), 32'd0);

        // start during LOAD is ignored
        in_valid = 1'b1; step();
        start = 1'b1; step(); start = 1'b0; in_valid = 1'b0;
        chk("start_in_load_count", 32'(count), 32'd3);

        // Reset right after a write edge
        rst_n = 1'b0; #1;
        chk("midrst_we",    32'(mem_we), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        step(); rst_n = 1'b1;
        in_valid = 1'b1; repeat (2) step(); in_valid = 1'b0;
        chk("postrst_count", 32'(count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            start    = ($urandom_range(0, 7) == 0);
            finish   = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            set_bundle(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 65535)));
            step();
        end
        rst_n = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder and instruction-memory loader: the encode direction of the opcode decode performed by the control unit. Accepts instruction fields (R-format, LW, SW, BEQ) over a valid/ready handshake, packs each into a 32-bit instruction word and writes it to consecutive instruction-memory words from address 0. Sits between the testbench/boot program source and the instruction memory, so programs are loaded through the same opcode encodings the control unit decodes.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; sampled only in IDLE and DONE
- finish  in  1  end the session; sampled only in LOAD
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_kind  in  2  00 R-format, 01 LW, 10 SW, 11 BEQ
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_shamt  in  5  shift amount (R only)
- in_funct  in  6  function code (R only)
- in_imm  in  16  immediate/offset (LW, SW, BEQ)
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  word address of write
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- full  out  1  count == 2^ADDR_W
- done  out  1  high while in DONE

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- IDLE: in_ready=0; start -> LOAD, count <= 0.
- LOAD: in_ready = !full (combinational from state and count only). Accept = in_valid && in_ready.
- On accept: mem_wdata <= packed word, mem_addr <= count[ADDR_W-1:0], mem_we <= 1, count <= count+1. No accept: mem_we <= 0; mem_addr/mem_wdata hold.
- Packing: R = {000000, rs, rt, rd, shamt, funct}; LW = {100011, rs, rt, imm}; SW = {101011, rs, rt, imm}; BEQ = {000100, rs, rt, imm}. Unused fields ignored (rd/shamt/funct for I-types, imm for R).
- finish in LOAD -> DONE. Accept coinciding with finish is written (strobe issues in the DONE-entry cycle).
- full: in_ready drops; bundles stall; no address wrap, no overwrite. finish still exits.
- DONE: done=1, in_ready=0, count holds; start -> LOAD, count <= 0.
- start ignored in LOAD; finish ignored in IDLE/DONE; in_valid without in_ready never writes.

## Timing
- Reset (async assert): state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, done 0.
- Latency: accept at edge N -> mem_we high for cycle N..N+1 with matching addr/data; one write per accept, back-to-back accepts give a continuous mem_we.
- Throughput: one instruction per cycle while !full.
- count/full update on the accept edge; in_ready falls the same cycle count reaches 2^ADDR_W.
- Reset mid-LOAD: session aborted, mem_we deasserts immediately, partial writes already done remain in memory.
- done asserts the cycle after the finish edge.

## Structure
- Shared package mips_pkg: OP_RTYPE/OP_LW/OP_SW/OP_BEQ opcode constants (also used by the control unit), kind encoding constants, state encoding.
- Sub-module instr_pack: combinational kind+fields -> 32-bit word; top holds FSM, counter, output registers.

## Test plan
- R add, rs=1 rt=2 rd=3 shamt=0 funct=0x20 after start -> mem_we one cycle, addr 0, wdata 0x00221820, count 1.
- Back-to-back LW (rs=1 rt=2 imm=4), SW (rs=1 rt=2 imm=8), BEQ (rs=1 rt=2 imm=0xFFFF) -> 0x8C220004 @0, 0xAC220008 @1, 0x1022FFFF @2 on consecutive cycles.
- ADDR_W=2, offer 5 bundles -> 4 writes at 0..3, full=1, in_ready=0, 5th held until finish; no write to 0 again.
- finish with a simultaneous accept -> that word written, done=1 next cycle, in_ready=0; later start -> count 0, next write at addr 0.
- rst_n low mid-stream after 3 writes -> mem_we 0 immediately, count 0, state IDLE; in_valid ignored until start.
- in_valid in IDLE and start during LOAD -> no writes / no count reset respectively.
